addr_pipe_elastic: RTL and testbench
====================================

# addr_pipe_elastic

Parametrised, elastic successor to the fixed-offset address pipeline stage. It chains DEPTH address/ID stages and adds a per-stage offset at every hop. It replaces global stall with per-stage valid/ready backpressure and bubble collapsing. An ID-matched flush kills every matching entry in all stages in a single cycle, and the block reports which stages were hit and the current occupancy. It sits between the request source and the address consumer in the global_stall test design.

## Interface
- ADDRESS_WIDTH, 16, address width; all address arithmetic is modulo 2^ADDRESS_WIDTH.
- ID_WIDTH, 4, transaction ID width.
- DEPTH, 4, number of stages; legal range 1..16.
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- stage_offsets  in  DEPTH*ADDRESS_WIDTH  offset for stage k in bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH]; quasi-static.
- in_valid  in  1  source presents an entry.
- in_ready  out  1  stage 0 can accept.
- in_address  in  ADDRESS_WIDTH  incoming address.
- in_id  in  ID_WIDTH  incoming ID.
- out_valid  out  1  stage DEPTH-1 holds an entry.
- out_ready  in  1  consumer accepts.
- out_address  out  ADDRESS_WIDTH  address held in stage DEPTH-1.
- out_id  out  ID_WIDTH  ID held in stage DEPTH-1.
- in_flush  in  1  flush request, single cycle.
- in_flush_id  in  ID_WIDTH  ID to kill.
- flush_hits  out  DEPTH  registered; bit k is set if stage k was killed at the previous edge.
- occupancy  out  $clog2(DEPTH+1)  registered count of valid stages.

## Operation
- **Per-stage state:** v[k], a[k], id[k]. On reset all are 0, and out_valid, flush_hits and occupancy are 0.
- **Kill term:** kill[k] = in_flush & v[k] & (id[k] == in_flush_id), evaluated on the current register contents.
- **Last-stage exception:** if v[DEPTH-1] & out_ready, the entry transfers and kill[DEPTH-1] is forced to 0. A handshake that completes wins over flush.
- **Ready chain (combinational):**
  - ready[DEPTH] = out_ready.
  - ready[k] = ~v[k] | kill[k] | ready[k+1].
  - in_ready = ready[0].
- **Advance:** if ready[k] and the upstream entry is valid and not killed, stage k loads:
  - a[k] <= (a[k-1] + offset[k]) mod 2^ADDRESS_WIDTH.
  - id[k] <= id[k-1].
  - v[k] <= 1.
  - Stage 0 uses in_address and offset[0].
- **Vacate:** if ready[k] and there is no upstream load, v[k] <= 0 and a[k], id[k] <= 0.
- **Hold:** if ready[k] = 0, stage k holds unchanged.
- **Killed entry:** it never moves forward. Its stage either loads the upstream entry or clears.
- **Incoming match:** if in_valid & in_flush & (in_id == in_flush_id), the handshake completes (in_ready is unaffected) but stage 0 does not load the entry. It is discarded.
- **Flush scope:** there is no flush propagation delay. All matching stages die at the same edge, and flush is not registered onward.
- **flush_hits:** flush_hits <= kill[DEPTH-1:0] every cycle.
- **occupancy:** occupancy <= number of v[k] set after the edge.
- **Ordering:** entries never reorder, and throughput is 1 per cycle when out_ready is held at 1.

## Timing
- **Latency:** an entry accepted at edge N is presented with out_valid at edge N+DEPTH-1 if there are no stalls.
- **Stall:** out_ready low holds the last stage. Upstream stages keep filling bubbles until all DEPTH stages are valid, then in_ready drops in the same cycle.
- **Ready path:** in_ready depends combinationally on out_ready, in_flush and in_flush_id through the whole chain. out_valid, out_address and out_id are registered only.
- **Reset mid-operation:** reset_n low clears every entry immediately (asynchronously). Entries in flight are lost, not drained.
- **Offset changes:** a change in stage_offsets takes effect on the next load of that stage. Entries already held are not recomputed.
- **Wrap-around:** the address sum drops carry-out. For example, 0xFFFF + 0x0002 gives 0x0001 with ADDRESS_WIDTH = 16.

## Test plan
- **Stream:** DEPTH=4, offsets {1,2,3,4}, out_ready=1. Send address 0x0010 with IDs 1..8 back-to-back -> every output address is 0x001A, IDs appear in order 1..8, first out_valid at cycle 3 after the first accept, no gaps.
- **Backpressure fill:** out_ready=0 while sending 6 entries -> 4 accepted and in_ready low thereafter, occupancy=4. Release out_ready -> the remaining 2 are accepted, all 6 emerge in order.
- **Multi-stage flush:** stages hold IDs {3,5,3,7}, hold out_ready=0, flush ID 3 -> stages 0 and 2 killed at one edge, flush_hits=4'b0101, occupancy=2. Then release out_ready -> outputs are IDs 7, 5.
- **Flush vs handshake:** last stage holds ID 9, out_ready=1, flush ID 9 in the same cycle -> the entry transfers, flush_hits[3]=0.
- **Incoming kill and wrap:** in_valid with in_id=2 and flush ID 2 -> in_ready=1, nothing enters, occupancy unchanged. Address 0xFFFF with all offsets 0x4000 -> output 0xFFFF.
- **Async reset:** pull reset_n low mid-stream between clock edges -> out_valid, occupancy and flush_hits are 0 immediately. After release, the first accept emerges DEPTH-1 cycles later.

Source files
------------

// File: rtl/addr_pipe_elastic_if.sv
// Handshake bundle for addr_pipe_elastic: request side, consumer side,
// ID-matched flush request and the status outputs.
//   master : request source / consumer / flush controller
//   slave  : the pipeline itself
interface addr_pipe_elastic_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned DEPTH         = 4
);
    localparam int unsigned OCC_WIDTH = $clog2(DEPTH + 1);

    logic [DEPTH*ADDRESS_WIDTH-1:0] stage_offsets;
    logic                           in_valid;
    logic                           in_ready;
    logic [ADDRESS_WIDTH-1:0]       in_address;
    logic [ID_WIDTH-1:0]            in_id;
    logic                           out_valid;
    logic                           out_ready;
    logic [ADDRESS_WIDTH-1:0]       out_address;
    logic [ID_WIDTH-1:0]            out_id;
    logic                           in_flush;
    logic [ID_WIDTH-1:0]            in_flush_id;
    logic [DEPTH-1:0]               flush_hits;
    logic [OCC_WIDTH-1:0]           occupancy;

    modport master (
        output stage_offsets, in_valid, in_address, in_id, out_ready,
               in_flush, in_flush_id,
        input  in_ready, out_valid, out_address, out_id, flush_hits, occupancy
    );

    modport slave (
        input  stage_offsets, in_valid, in_address, in_id, out_ready,
               in_flush, in_flush_id,
        output in_ready, out_valid, out_address, out_id, flush_hits, occupancy
    );
endinterface

// File: rtl/addr_pipe_elastic.sv
// Elastic address/ID pipeline of DEPTH stages. Each stage adds its own offset
// when it loads, bubbles collapse under per-stage valid/ready backpressure,
// and an ID-matched flush kills every matching entry in one cycle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of addr_pipe_elastic_if (in/out handshakes, flush,
//            stage offsets, flush_hits and occupancy status)
module addr_pipe_elastic #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    addr_pipe_elastic_if.slave   bus
);
    localparam int unsigned OCC_WIDTH = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]         v_q;
    logic [ADDRESS_WIDTH-1:0] a_q  [DEPTH];
    logic [ID_WIDTH-1:0]      id_q [DEPTH];
    logic [DEPTH-1:0]         flush_hits_q;
    logic [OCC_WIDTH-1:0]     occupancy_q;

    logic [DEPTH-1:0]         kill_c;
    logic [DEPTH-1:0]         ready_c;
    logic [DEPTH-1:0]         v_next_c;
    logic [ADDRESS_WIDTH-1:0] a_next_c  [DEPTH];
    logic [ID_WIDTH-1:0]      id_next_c [DEPTH];
    logic [OCC_WIDTH-1:0]     occ_next_c;
    logic                     in_take_c;

    // Kill terms, ready chain, per-stage next state and next occupancy
    always_comb begin
        logic rdy;
        kill_c     = '0;
        ready_c    = '0;
        v_next_c   = v_q;
        a_next_c   = a_q;
        id_next_c  = id_q;
        occ_next_c = '0;
        // An incoming entry that matches the flush is accepted but dropped
        in_take_c  = bus.in_valid & ~(bus.in_flush & (bus.in_id == bus.in_flush_id));

        for (int k = 0; k < int'(DEPTH); k++) begin
            kill_c[k] = bus.in_flush & v_q[k] & (id_q[k] == bus.in_flush_id);
        end
        // A completing output handshake takes precedence over the flush
        if (v_q[DEPTH-1] & bus.out_ready) begin
            kill_c[DEPTH-1] = 1'b0;
        end

        rdy = bus.out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            rdy        = ~v_q[k] | kill_c[k] | rdy;
            ready_c[k] = rdy;
        end

        // Stage 0 takes from the input port
        if (ready_c[0]) begin
            v_next_c[0]  = in_take_c;
            a_next_c[0]  = in_take_c ? bus.in_address + bus.stage_offsets[0 +: ADDRESS_WIDTH] : '0;
            id_next_c[0] = in_take_c ? bus.in_id : '0;
        end

        // Later stages take from their predecessor unless it was killed
        for (int k = 1; k < int'(DEPTH); k++) begin
            if (ready_c[k]) begin
                if (v_q[k-1] & ~kill_c[k-1]) begin
                    v_next_c[k]  = 1'b1;
                    a_next_c[k]  = a_q[k-1] + bus.stage_offsets[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    id_next_c[k] = id_q[k-1];
                end else begin
                    v_next_c[k]  = 1'b0;
                    a_next_c[k]  = '0;
                    id_next_c[k] = '0;
                end
            end
        end

        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_next_c = occ_next_c + OCC_WIDTH'(v_next_c[k]);
        end
    end

    // Stage registers and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q          <= '0;
            flush_hits_q <= '0;
            occupancy_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                a_q[k]  <= '0;
                id_q[k] <= '0;
            end
        end else begin
            v_q          <= v_next_c;
            a_q          <= a_next_c;
            id_q         <= id_next_c;
            flush_hits_q <= kill_c;
            occupancy_q  <= occ_next_c;
        end
    end

    assign bus.in_ready    = ready_c[0];
    assign bus.out_valid   = v_q[DEPTH-1];
    assign bus.out_address = a_q[DEPTH-1];
    assign bus.out_id      = id_q[DEPTH-1];
    assign bus.flush_hits  = flush_hits_q;
    assign bus.occupancy   = occupancy_q;

endmodule

// File: tb/tb_addr_pipe_elastic.sv
// Self-checking bench for addr_pipe_elastic (DEPTH=4, 16-bit address, 4-bit ID).
module tb_addr_pipe_elastic;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned D  = 4;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addr_pipe_elastic_if #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(D)) bus ();

    addr_pipe_elastic #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } ent_t;

    typedef struct packed {
        logic          iv;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          ordy;
        logic          fl;
        logic [IW-1:0] fid;
        logic          e_rdy;
        logic          e_ov;
        logic [IW-1:0] e_id;
        logic [AW-1:0] e_addr;
        logic [2:0]    e_occ;
        logic [D-1:0]  e_fh;
    } vec_t;

    // Reference: ordered list of live entries, oldest first, with final address
    ent_t          mq[$];
    logic [AW-1:0] offs [D];
    vec_t          vecs [8];
    int            n_pass;
    int            n_total;

    logic          s_rdy;
    logic          s_ov;
    logic [IW-1:0] s_oid;
    logic [AW-1:0] s_oaddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] off_sum();
        logic [AW-1:0] s;
        s = '0;
        for (int k = 0; k < int'(D); k++) s = s + offs[k];
        return s;
    endfunction

    task automatic set_offsets();
        for (int k = 0; k < int'(D); k++) bus.stage_offsets[k*AW +: AW] = offs[k];
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_address  = '0;
        bus.in_id       = '0;
        bus.out_ready   = 1'b0;
        bus.in_flush    = 1'b0;
        bus.in_flush_id = '0;
    endtask

    // One clock cycle with the inputs currently driven; checks against the model
    task automatic tick();
        logic          any_hit, hs, acc, fl, iv;
        logic [IW-1:0] fid, iid;
        logic [AW-1:0] iaddr;
        int            n_kill;
        ent_t          keep[$];
        ent_t          e;
        #1;
        s_rdy   = bus.in_ready;
        s_ov    = bus.out_valid;
        s_oid   = bus.out_id;
        s_oaddr = bus.out_address;
        fl = bus.in_flush; fid = bus.in_flush_id;
        iv = bus.in_valid; iid = bus.in_id; iaddr = bus.in_address;
        any_hit = 1'b0;
        foreach (mq[i]) if (fl && mq[i].id == fid) any_hit = 1'b1;
        check("in_ready", 32'(s_rdy), 32'((mq.size() < int'(D)) || bus.out_ready || any_hit));
        if (mq.size() == 0) check("out_valid_idle", 32'(s_ov), 32'd0);
        else if (s_ov) begin
            check("out_id", 32'(s_oid), 32'(mq[0].id));
            check("out_address", 32'(s_oaddr), 32'(mq[0].addr));
        end
        hs  = s_ov & bus.out_ready;
        acc = iv & s_rdy;
        @(posedge clk);
        #1;
        if (hs && mq.size() > 0) void'(mq.pop_front());
        n_kill = 0;
        if (fl) begin
            foreach (mq[i]) begin
                if (mq[i].id == fid) n_kill++;
                else keep.push_back(mq[i]);
            end
            mq = keep;
        end
        if (acc && !(fl && iid == fid)) begin
            e.id   = iid;
            e.addr = iaddr + off_sum();
            mq.push_back(e);
        end
        check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        check("flush_hits_count", 32'($countones(bus.flush_hits)), 32'(n_kill));
    endtask

    task automatic wait_ov(input int budget, output int n);
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check("out_valid_reached", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first, last, nvalid, nexp, sent, got, n, occ_before;
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        for (int k = 0; k < int'(D); k++) offs[k] = AW'(k + 1);
        set_offsets();

        // Reset state
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_occupancy", 32'(bus.occupancy), 32'd0);
        check("reset_flush_hits", 32'(bus.flush_hits), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Fill to {3,5,3,7} under backpressure, stall when full, flush ID 3, drain
        vecs[0] = '{1'b1, 16'h1000, 4'd7, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd1, 4'b0000};
        vecs[1] = '{1'b1, 16'h2000, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd2, 4'b0000};
        vecs[2] = '{1'b1, 16'h3000, 4'd5, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd3, 4'b0000};
        vecs[3] = '{1'b1, 16'h4000, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 16'h100A, 3'd4, 4'b0000};
        vecs[4] = '{1'b1, 16'h5000, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 16'h100A, 3'd4, 4'b0000};
        vecs[5] = '{1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd7, 16'h100A, 3'd2, 4'b0101};
        vecs[6] = '{1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 16'h300A, 3'd1, 4'b0000};
        vecs[7] = '{1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd0, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            bus.in_valid    = vecs[i].iv;
            bus.in_address  = vecs[i].addr;
            bus.in_id       = vecs[i].id;
            bus.out_ready   = vecs[i].ordy;
            bus.in_flush    = vecs[i].fl;
            bus.in_flush_id = vecs[i].fid;
            tick();
            check($sformatf("vec%0d_in_ready", i), 32'(s_rdy), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_id", i), 32'(bus.out_id), 32'(vecs[i].e_id));
                check($sformatf("vec%0d_out_address", i), 32'(bus.out_address), 32'(vecs[i].e_addr));
            end
            check($sformatf("vec%0d_occupancy", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
            check($sformatf("vec%0d_flush_hits", i), 32'(bus.flush_hits), 32'(vecs[i].e_fh));
        end
        idle_inputs();

        // Back-to-back stream with the consumer always ready
        bus.out_ready  = 1'b1;
        bus.in_address = 16'h0010;
        first = -1; last = -1; nvalid = 0; nexp = 1;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = (c < 8);
            bus.in_id    = IW'(c + 1);
            tick();
            if (bus.out_valid) begin
                if (first < 0) first = c;
                check("stream_id", 32'(bus.out_id), 32'(nexp));
                check("stream_addr", 32'(bus.out_address), 32'h001A);
                nexp++; nvalid++; last = c;
            end
        end
        check("stream_first_valid", 32'(first), 32'd3);
        check("stream_count", 32'(nvalid), 32'd8);
        check("stream_no_gaps", 32'(last - first), 32'd7);
        idle_inputs();

        // Backpressure fill: 6 offered, 4 fit, then release
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid   = (sent < 6);
            bus.in_id      = IW'(sent + 1);
            bus.in_address = AW'(16'h0100 + sent);
            tick();
            if (s_rdy && bus.in_valid) sent++;
        end
        check("bp_accepted", 32'(sent), 32'd4);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_occupancy", 32'(bus.occupancy), 32'd4);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            bus.in_valid   = (sent < 6);
            bus.in_id      = IW'(sent + 1);
            bus.in_address = AW'(16'h0100 + sent);
            if (bus.out_valid) begin
                check("bp_order_id", 32'(bus.out_id), 32'(got + 1));
                check("bp_order_addr", 32'(bus.out_address), 32'(AW'(16'h010A + got)));
                got++;
            end
            tick();
            if (s_rdy && bus.in_valid) sent++;
        end
        check("bp_all_out", 32'(got), 32'd6);
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();

        // Flush and output handshake on the same ID in the same cycle
        bus.in_valid = 1'b1; bus.in_id = 4'd9; bus.in_address = 16'h0200;
        tick();
        bus.in_valid = 1'b0;
        wait_ov(10, n);
        check("fvh_held_id", 32'(bus.out_id), 32'd9);
        bus.out_ready = 1'b1; bus.in_flush = 1'b1; bus.in_flush_id = 4'd9;
        tick();
        check("fvh_sampled_id", 32'(s_oid), 32'd9);
        check("fvh_flush_hits3", 32'(bus.flush_hits[3]), 32'd0);
        check("fvh_occupancy", 32'(bus.occupancy), 32'd0);
        idle_inputs();

        // Incoming entry that matches the flush is accepted and dropped
        bus.in_valid = 1'b1; bus.in_id = 4'd4; bus.in_address = 16'h0300;
        tick();
        occ_before = int'(bus.occupancy);
        bus.in_id = 4'd2; bus.in_flush = 1'b1; bus.in_flush_id = 4'd2;
        tick();
        check("inkill_in_ready", 32'(s_rdy), 32'd1);
        check("inkill_occupancy", 32'(bus.occupancy), 32'(occ_before));
        check("inkill_occupancy_one", 32'(bus.occupancy), 32'd1);
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("inkill_drained", 32'(bus.occupancy), 32'd0);

        // Address wrap-around
        for (int k = 0; k < int'(D); k++) offs[k] = 16'h4000;
        set_offsets();
        bus.in_valid = 1'b1; bus.in_id = 4'd5; bus.in_address = 16'hFFFF;
        tick();
        bus.in_valid = 1'b0;
        wait_ov(10, n);
        check("wrap_addr", 32'(bus.out_address), 32'h0000FFFF);
        tick();

        // Asynchronous reset between edges, then restart latency
        for (int k = 0; k < int'(D); k++) offs[k] = AW'(k + 1);
        set_offsets();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_id = IW'(c + 1); bus.in_address = AW'(16'h0500 + c);
            tick();
        end
        bus.in_valid = 1'b0; bus.in_flush = 1'b1; bus.in_flush_id = 4'd2;
        tick();
        bus.in_flush = 1'b0; bus.in_valid = 1'b1; bus.in_id = 4'd6;
        #2 reset_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(bus.out_valid), 32'd0);
        check("areset_occupancy", 32'(bus.occupancy), 32'd0);
        check("areset_flush_hits", 32'(bus.flush_hits), 32'd0);
        mq.delete();
        #2 reset_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_id = 4'd7; bus.in_address = 16'h0400;
        tick();
        check("areset_accept", 32'(s_rdy), 32'd1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        wait_ov(10, n);
        check("areset_latency", 32'(n), 32'd3);
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // Randomised traffic against the ordered-list model
        for (int k = 0; k < int'(D); k++) offs[k] = AW'($urandom);
        set_offsets();
        for (int c = 0; c < 600; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_id       = IW'($urandom_range(0, 3));
            bus.in_address  = AW'($urandom);
            bus.out_ready   = ($urandom_range(0, 9) < (((c / 100) % 2 == 1) ? 8 : 3));
            bus.in_flush    = ($urandom_range(0, 7) == 0);
            bus.in_flush_id = IW'($urandom_range(0, 3));
            tick();
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("drain_model_empty", 32'(mq.size()), 32'd0);
        check("drain_occupancy", 32'(bus.occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
